keypad_entry_scanner: RTL and testbench
=======================================

// Module: keypad_entry_scanner
// PURPOSE
//  Parametrised 4x4 hex keypad scanner with settle/sample timing, full-matrix debounce, single-key press
//  events, a shift-in digit entry buffer, NUM_OPERANDS committed operand registers and a registered
//  active-low 7-segment image of the entry. Sits between the board keypad pins and downstream arithmetic/display logic.
// PARAMETERS
//  SCAN_TICKS     100000  clk cycles each column is driven (1 ms at 100 MHz); must be > SETTLE_TICKS
//  SETTLE_TICKS   8       cycles after column change before rows are sampled; >= 1
//  DEBOUNCE_SCANS 4       consecutive identical full scans required before the debounced matrix updates; >= 1
//  NUM_DIGITS     4       hex digits per entry/operand; OPW = 4*NUM_DIGITS
//  NUM_OPERANDS   2       committed operand registers; SELW = max(1,$clog2(NUM_OPERANDS))
// PORTS
//  clk          in   1                  system clock
//  rst          in   1                  synchronous reset, active-high
//  row          in   4                  keypad rows, active-low (row[3]=R1 .. row[0]=R4)
//  col          out  4                  keypad columns, active-low one-hot (col[3]=C1 .. col[0]=C4)
//  clear        in   1                  pulse: empty entry buffer
//  commit       in   1                  pulse: copy entry into operand[op_sel], then empty entry
//  op_sel       in   SELW               operand index for commit
//  key_valid    out  1                  1-cycle pulse per accepted key press
//  key_code     out  4                  hex code of last accepted key (held)
//  entry        out  OPW                entry digits, newest in [3:0]
//  entry_count  out  $clog2(NUM_DIGITS+1)  valid digits in entry, 0..NUM_DIGITS
//  operands     out  NUM_OPERANDS*OPW   operand i at [i*OPW +: OPW]
//  seg_n        out  8*NUM_DIGITS       active-low segments, digit i at [8*i +: 8], bit0=a..bit6=g, bit7=dp
// BEHAVIOUR
//  Clock is clk; reset is rst: one clock, synchronous, active-high.
//  Reset: col=4'b0111 (C1), tick/column/stable counters=0, raw and debounced matrices=0, key_valid=0,
//   key_code=0, entry=0, entry_count=0, all operands=0, seg_n=all 1s. Reset mid-scan aborts the scan and
//   discards any partially debounced key.
//  Scan: column index c cycles C1,C2,C3,C4,C1...; tick counts 0..SCAN_TICKS-1 per column, col changes
//   the cycle tick wraps. At tick==SETTLE_TICKS the 4 inverted row bits are stored into raw[4c +: 4].
//   Full scan period = 4*SCAN_TICKS cycles; scan ends on the C4 sample.
//  Debounce: at scan end, if raw == previous-scan raw then stable++ (saturate at DEBOUNCE_SCANS) else stable=0;
//   when stable reaches DEBOUNCE_SCANS, debounced <= raw. A key first seen in scan k updates debounced at end
//   of scan k+DEBOUNCE_SCANS.
//  Key map (R1..R4): C1 = 1,4,7,F; C2 = 2,5,8,0; C3 = 3,6,9,E; C4 = A,B,C,D.
//  Event: when debounced goes from all-zero to exactly one bit set, key_valid=1 for the next cycle and key_code
//   updates. Multi-key matrices produce no event; a new event requires return to all-zero first.
//  Entry: on key_valid, entry <= {entry[OPW-5:0], key_code}; entry_count++ saturating at NUM_DIGITS
//   (oldest digit is dropped once full).
//  Commit with op_sel < NUM_OPERANDS: operands[op_sel] <= entry (pre-update value); entry=0, count=0.
//   op_sel >= NUM_OPERANDS: commit ignored, nothing changes.
//  Same-cycle priority: clear > commit > key. clear+key: key discarded. commit+key: operand gets the old entry,
//   entry becomes {0,key_code}, count=1. clear+commit: clear only, operands unchanged.
//  Display: seg_n registered, 1 cycle after entry/count change. Digit i shows the active-low hex font of entry
//   nibble i when i < entry_count, otherwise 8'hFF. Active-high patterns 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F
//   77 7C 39 5E 79 71, then inverted. dp always off (bit7=1).
// TESTING (SCAN_TICKS=16, SETTLE_TICKS=4, DEBOUNCE_SCANS=2, NUM_DIGITS=4, NUM_OPERANDS=2)
//  Reset, row=4'hF -> col sequence 0111,1011,1101,1110 every 16 cycles; key_valid never asserts; seg_n=32'hFFFFFFFF.
//  Hold R2 during C3 for 4 scans -> exactly one key_valid, key_code=6, entry=16'h0006, count=1,
//   seg_n[7:0]=8'h82, seg_n[31:8] all 1s.
//  Press/release 1,2,3,4,5 -> entry=16'h2345, count=4, five key_valid pulses.
//  Bounce: R1/C1 toggles every other scan for 6 scans, then holds -> no event until 2 stable scans, then one event code=1.
//  Press F and 0 together -> no event; release all, press A -> key_code=A.
//  Entry 16'h00AB count=2, op_sel=1, commit with simultaneous key 7 -> operands[31:16]=16'h00AB, entry=16'h0007,
//   count=1. op_sel=1 with NUM_OPERANDS=3 vs op_sel=3 -> the out-of-range commit is ignored. Assert rst mid-scan -> all reset values next cycle.

Source files
------------

// File: rtl/keypad_entry_scanner.sv
// keypad_entry_scanner: 4x4 hex keypad column scanner with settle/sample timing,
// full-matrix debounce, single-key press events, a shift-in hex entry buffer,
// committed operand registers and a registered active-low 7-segment image of the entry.
module keypad_entry_scanner #(
   parameter int SCAN_TICKS     = 100000,
   parameter int SETTLE_TICKS   = 8,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int NUM_DIGITS     = 4,
   parameter int NUM_OPERANDS   = 2,
   localparam int OPW  = 4 * NUM_DIGITS,
   localparam int SELW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
   localparam int CNTW = $clog2(NUM_DIGITS + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    row,
   output logic [3:0]                    col,
   input  logic                          clear,
   input  logic                          commit,
   input  logic [SELW-1:0]               op_sel,
   output logic                          key_valid,
   output logic [3:0]                    key_code,
   output logic [OPW-1:0]                entry,
   output logic [CNTW-1:0]               entry_count,
   output logic [NUM_OPERANDS*OPW-1:0]   operands,
   output logic [8*NUM_DIGITS-1:0]       seg_n
);

   localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [TW-1:0]   TICK_LAST   = TW'(SCAN_TICKS - 1);
   localparam logic [TW-1:0]   TICK_SAMPLE = TW'(SETTLE_TICKS);
   localparam logic [SW-1:0]   STABLE_MAX  = SW'(DEBOUNCE_SCANS);
   localparam logic [CNTW-1:0] COUNT_MAX   = CNTW'(NUM_DIGITS);
   localparam logic [31:0]     NUM_OPS_U   = 32'(NUM_OPERANDS);
   // Hex code of matrix bit b (b = 4*column + row, row 3 = R1) at nibble b.
   localparam logic [63:0]     KEY_MAP     = 64'hABCD_369E_2580_147F;

   logic [TW-1:0]   tick_q, tick_d;
   logic [1:0]      col_idx_q, col_idx_d;
   logic [15:0]     raw_q, raw_d, prev_q, prev_d, deb_q, deb_d;
   logic [SW-1:0]   stable_q, stable_d;
   logic            key_valid_q, key_valid_d;
   logic [3:0]      key_code_q, key_code_d;
   logic [OPW-1:0]  entry_q, entry_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [NUM_OPERANDS-1:0][OPW-1:0] operands_q, operands_d;
   logic [8*NUM_DIGITS-1:0] seg_q, seg_d;

   logic            sample, scan_end, commit_ok;
   logic [15:0]     raw_sampled;

   function automatic logic [3:0] key_encode(input logic [15:0] m);
      logic [3:0] code;
      code = 4'h0;
      for (int b = 0; b < 16; b++) begin
         if (m[b]) code = code | KEY_MAP[4*b +: 4];
      end
      return code;
   endfunction

   function automatic logic is_onehot(input logic [15:0] m);
      return (m != 16'd0) && ((m & (m - 16'd1)) == 16'd0);
   endfunction

   function automatic logic [6:0] hex_font(input logic [3:0] d);
      logic [6:0] f;
      case (d)
         4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
         4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
         4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
         4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
      endcase
      return f;
   endfunction

   // Column timing, row capture and end-of-scan debounce / press-event detection.
   always_comb begin
      // NOTE: every combinational output is given a default first so no path infers a latch.
      sample      = (tick_q == TICK_SAMPLE);
      scan_end    = sample && (col_idx_q == 2'd3);
      tick_d      = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
      col_idx_d   = (tick_q == TICK_LAST) ? col_idx_q + 2'd1 : col_idx_q;
      raw_sampled = raw_q;
      if (sample) raw_sampled[{col_idx_q, 2'b00} +: 4] = ~row;
      raw_d       = raw_sampled;
      prev_d      = prev_q;
      stable_d    = stable_q;
      deb_d       = deb_q;
      key_valid_d = 1'b0;
      key_code_d  = key_code_q;
      if (scan_end) begin
         prev_d   = raw_sampled;
         stable_d = (raw_sampled == prev_q)
                  ? ((stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1))
                  : '0;
         if (stable_d == STABLE_MAX) begin
            deb_d = raw_sampled;
            // A press event needs a released matrix before and exactly one key now.
            if ((deb_q == 16'd0) && is_onehot(raw_sampled)) begin
               key_valid_d = 1'b1;
               key_code_d  = key_encode(raw_sampled);
            end
         end
      end
   end

   // Entry buffer and operand registers; clear beats commit beats the key.
   always_comb begin
      entry_d    = entry_q;
      count_d    = count_q;
      operands_d = operands_q;
      commit_ok  = commit && (32'(op_sel) < NUM_OPS_U);
      if (clear) begin
         entry_d = '0;
         count_d = '0;
      end else if (commit_ok) begin
         operands_d[op_sel] = entry_q;
         entry_d = key_valid_q ? OPW'(key_code_q) : '0;
         count_d = key_valid_q ? CNTW'(1) : '0;
      end else if (key_valid_q) begin
         entry_d = (entry_q << 4) | OPW'(key_code_q);
         count_d = (count_q == COUNT_MAX) ? count_q : count_q + CNTW'(1);
      end
   end

   // Display image: font of each valid digit, blank (all segments off) otherwise.
   always_comb begin
      seg_d = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (CNTW'(i) < count_q) seg_d[8*i +: 8] = ~{1'b0, hex_font(entry_q[4*i +: 4])};
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q      <= '0;
         col_idx_q   <= '0;
         raw_q       <= '0;
         prev_q      <= '0;
         deb_q       <= '0;
         stable_q    <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         entry_q     <= '0;
         count_q     <= '0;
         // NOTE: operand registers are cleared by reset since downstream logic may read them at once.
         operands_q  <= '0;
         seg_q       <= '1;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         tick_q      <= tick_d;
         col_idx_q   <= col_idx_d;
         raw_q       <= raw_d;
         prev_q      <= prev_d;
         deb_q       <= deb_d;
         stable_q    <= stable_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         entry_q     <= entry_d;
         count_q     <= count_d;
         operands_q  <= operands_d;
         seg_q       <= seg_d;
      end
   end

   assign col         = ~(4'b1000 >> col_idx_q);
   assign key_valid   = key_valid_q;
   assign key_code    = key_code_q;
   assign entry       = entry_q;
   assign entry_count = count_q;
   assign operands    = operands_q;
   assign seg_n       = seg_q;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Bench for keypad_entry_scanner: keypad matrix model, key-event scoreboard,
// table of key entries plus hand sequences for bounce, multi-key, commit and reset.
module tb_keypad_entry_scanner;

   localparam int ST   = 16;
   localparam int SCAN = 4 * ST;

   logic        clk = 1'b0;
   logic        rst, clear, commit;
   logic        op_sel;
   logic [1:0]  op_sel3;
   logic [3:0]  row, col, col3;
   logic        key_valid, key_valid3;
   logic [3:0]  key_code, key_code3;
   logic [15:0] entry, entry3;
   logic [2:0]  count, count3;
   logic [31:0] operands;
   logic [47:0] operands3;
   logic [31:0] seg_n, seg_n3;
   logic [15:0] keys;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          pulses   = 0;
   logic [3:0]  exp_q[$];
   logic [3:0]  exp_code;

   localparam logic [7:0] FONT [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   typedef struct {
      logic        do_clear;
      logic [3:0]  code;
      logic [15:0] exp_entry;
      int          exp_count;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;

   keypad_entry_scanner #(.SCAN_TICKS(ST), .SETTLE_TICKS(4), .DEBOUNCE_SCANS(2),
                          .NUM_DIGITS(4), .NUM_OPERANDS(2)) u_dut (
      .clk(clk), .rst(rst), .row(row), .col(col), .clear(clear), .commit(commit),
      .op_sel(op_sel), .key_valid(key_valid), .key_code(key_code), .entry(entry),
      .entry_count(count), .operands(operands), .seg_n(seg_n));

   keypad_entry_scanner #(.SCAN_TICKS(ST), .SETTLE_TICKS(4), .DEBOUNCE_SCANS(2),
                          .NUM_DIGITS(4), .NUM_OPERANDS(3)) u_dut3 (
      .clk(clk), .rst(rst), .row(row), .col(col3), .clear(clear), .commit(commit),
      .op_sel(op_sel3), .key_valid(key_valid3), .key_code(key_code3), .entry(entry3),
      .entry_count(count3), .operands(operands3), .seg_n(seg_n3));

   // Keypad matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (col[3-c] == 1'b0) row = row & ~keys[4*c +: 4];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every key_valid pulse must match the oldest expected code.
   always @(negedge clk) begin
      if (!rst && key_valid === 1'b1) begin
         pulses++;
         if (exp_q.size() == 0) begin
            check("spurious key_valid", 64'(key_valid), 64'd0);
         end else begin
            exp_code = exp_q.pop_front();
            check("key_code", 64'(key_code), 64'(exp_code));
            check("dut3 key_valid", 64'(key_valid3), 64'd1);
         end
      end
   end

   function automatic int key_bit(input logic [3:0] code);
      case (code)
         4'h1: return 3;   4'h4: return 2;   4'h7: return 1;   4'hF: return 0;
         4'h2: return 7;   4'h5: return 6;   4'h8: return 5;   4'h0: return 4;
         4'h3: return 11;  4'h6: return 10;  4'h9: return 9;   4'hE: return 8;
         4'hA: return 15;  4'hB: return 14;  4'hC: return 13;  default: return 12;
      endcase
   endfunction

   function automatic logic [31:0] exp_seg(input logic [15:0] e, input int n);
      logic [31:0] s;
      logic [3:0]  nib;
      for (int i = 0; i < 4; i++) begin
         nib = e[4*i +: 4];
         s[8*i +: 8] = (i < n) ? ~FONT[nib] : 8'hFF;
      end
      return s;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      cycles(1);
      clear = 1'b0;
      cycles(1);
   endtask

   task automatic press_key(input logic [3:0] code, input bit expect_evt);
      keys = 16'h0;
      keys[key_bit(code)] = 1'b1;
      if (expect_evt) exp_q.push_back(code);
      cycles(5 * SCAN);
      keys = 16'h0;
      cycles(5 * SCAN);
      check("event drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_entry(input string tag, input logic [15:0] e, input int n);
      check({tag, " entry"}, 64'(entry), 64'(e));
      check({tag, " count"}, 64'(count), 64'(n));
      check({tag, " seg_n"}, 64'(seg_n), 64'(exp_seg(e, n)));
   endtask

   task automatic wait_scan_start();
      int n = 0;
      while (col !== 4'b1110 && n < 300) begin cycles(1); n++; end
      while (col !== 4'b0111 && n < 600) begin cycles(1); n++; end
      check("scan alignment col", 64'(col), 64'h7);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " col"}, 64'(col), 64'h7);
      check({tag, " key_valid"}, 64'(key_valid), 64'd0);
      check({tag, " key_code"}, 64'(key_code), 64'd0);
      check({tag, " entry"}, 64'(entry), 64'd0);
      check({tag, " count"}, 64'(count), 64'd0);
      check({tag, " operands"}, 64'(operands), 64'd0);
      check({tag, " operands3"}, 64'(operands3), 64'd0);
      check({tag, " seg_n"}, 64'(seg_n), 64'hFFFF_FFFF);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int n;
      vecs[0] = '{1'b0, 4'h6, 16'h0006, 1};
      vecs[1] = '{1'b1, 4'h1, 16'h0001, 1};
      vecs[2] = '{1'b0, 4'h2, 16'h0012, 2};
      vecs[3] = '{1'b0, 4'h3, 16'h0123, 3};
      vecs[4] = '{1'b0, 4'h4, 16'h1234, 4};
      vecs[5] = '{1'b0, 4'h5, 16'h2345, 4};

      rst = 1'b1; clear = 1'b0; commit = 1'b0; op_sel = 1'b0; op_sel3 = 2'd0; keys = 16'h0;
      cycles(3);
      check_reset_state("reset");

      // Column walk after reset release.
      rst = 1'b0;
      cycles(15);
      check("col C1 hold", 64'(col), 64'h7);
      cycles(1);
      check("col C2", 64'(col), 64'hB);
      cycles(ST);
      check("col C3", 64'(col), 64'hD);
      cycles(ST);
      check("col C4", 64'(col), 64'hE);
      cycles(ST);
      check("col C1 wrap", 64'(col), 64'h7);

      cycles(4 * SCAN);
      check("idle pulses", 64'(pulses), 64'd0);
      check("idle seg_n", 64'(seg_n), 64'hFFFF_FFFF);

      // Table-driven key entry, including shift-out once the buffer is full.
      for (int i = 0; i < 6; i++) begin
         if (vecs[i].do_clear) pulse_clear();
         p0 = pulses;
         press_key(vecs[i].code, 1'b1);
         check($sformatf("vec%0d pulses", i), 64'(pulses - p0), 64'd1);
         check($sformatf("vec%0d key_code", i), 64'(key_code), 64'(vecs[i].code));
         check_entry($sformatf("vec%0d", i), vecs[i].exp_entry, vecs[i].exp_count);
      end

      // Bounce: key 1 alternates each scan for 6 scans, then holds.
      pulse_clear();
      p0 = pulses;
      wait_scan_start();
      for (int k = 0; k < 3; k++) begin
         keys = 16'h0; keys[key_bit(4'h1)] = 1'b1;
         cycles(SCAN);
         keys = 16'h0;
         cycles(SCAN);
      end
      exp_q.push_back(4'h1);
      keys[key_bit(4'h1)] = 1'b1;
      cycles(2 * SCAN);
      check("bounce no early event", 64'(pulses - p0), 64'd0);
      cycles(SCAN);
      check("bounce one event", 64'(pulses - p0), 64'd1);
      keys = 16'h0;
      cycles(5 * SCAN);
      check_entry("bounce", 16'h0001, 1);

      // Two keys together produce nothing; a later single key does.
      p0 = pulses;
      keys = 16'h0; keys[key_bit(4'hF)] = 1'b1; keys[key_bit(4'h0)] = 1'b1;
      cycles(5 * SCAN);
      keys = 16'h0;
      cycles(5 * SCAN);
      check("multikey pulses", 64'(pulses - p0), 64'd0);
      press_key(4'hA, 1'b1);
      check("after multikey key_code", 64'(key_code), 64'hA);
      check_entry("after multikey", 16'h001A, 2);

      // Commit coinciding with a key event; dut3 sees an out-of-range op_sel.
      pulse_clear();
      press_key(4'hA, 1'b1);
      press_key(4'hB, 1'b1);
      check_entry("pre-commit", 16'h00AB, 2);
      keys = 16'h0; keys[key_bit(4'h7)] = 1'b1;
      exp_q.push_back(4'h7);
      n = 0;
      while (key_valid !== 1'b1 && n < 6 * SCAN) begin cycles(1); n++; end
      check("commit key_valid seen", 64'(key_valid), 64'd1);
      commit = 1'b1; op_sel = 1'b1; op_sel3 = 2'd3;
      cycles(1);
      commit = 1'b0;
      cycles(1);
      check("commit operand1", 64'(operands[31:16]), 64'h00AB);
      check("commit operand0", 64'(operands[15:0]), 64'h0000);
      check_entry("commit+key", 16'h0007, 1);
      check("oor commit operands3", 64'(operands3), 64'd0);
      check("oor commit entry3", 64'(entry3), 64'h0AB7);
      check("oor commit count3", 64'(count3), 64'd3);
      keys = 16'h0;
      cycles(5 * SCAN);

      commit = 1'b1; op_sel = 1'b0; op_sel3 = 2'd1;
      cycles(1);
      commit = 1'b0;
      cycles(1);
      check("commit2 operands", 64'(operands), 64'h00AB_0007);
      check_entry("commit2", 16'h0000, 0);
      check("commit2 operands3", 64'(operands3), 64'h0000_0AB7_0000);
      check("commit2 entry3", 64'(entry3), 64'h0000);

      // Clear and commit together: clear only.
      press_key(4'h9, 1'b1);
      check_entry("pre-clear+commit", 16'h0009, 1);
      check("pre-clear+commit entry3", 64'(entry3), 64'h0009);
      clear = 1'b1; commit = 1'b1; op_sel = 1'b1; op_sel3 = 2'd2;
      cycles(1);
      clear = 1'b0; commit = 1'b0;
      cycles(1);
      check_entry("clear+commit", 16'h0000, 0);
      check("clear+commit operands", 64'(operands), 64'h00AB_0007);
      check("clear+commit operands3", 64'(operands3), 64'h0000_0AB7_0000);

      // Reset in the middle of a scan with a key partly debounced.
      press_key(4'hC, 1'b1);
      check_entry("pre-reset", 16'h000C, 1);
      p0 = pulses;
      keys = 16'h0; keys[key_bit(4'h5)] = 1'b1;
      cycles(SCAN + 40);
      rst = 1'b1; keys = 16'h0;
      cycles(1);
      check_reset_state("mid-scan reset");
      rst = 1'b0;
      cycles(5 * SCAN);
      check("post-reset pulses", 64'(pulses - p0), 64'd0);
      check("post-reset entry", 64'(entry), 64'd0);

      check("final queue empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
